// File: rtl/auth_pkg.sv
// auth_pkg
// Shared types and constants for the challenge_auth sequencer.
//   state_t        : sequencer state encoding
//   DEFAULT_KEY    : shared secret XORed with the challenge
//   BYTE_W/WORD_W  : UART byte width and challenge word width
//   expected_resp  : response the remote side must return for a challenge
package auth_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] DEFAULT_KEY = 16'h5A3C;

  typedef enum logic [3:0] {
    IDLE,
    ROLL,
    LATCH,
    TX_HI,
    TX_LO,
    RX_HI,
    RX_LO,
    CHECK,
    PASS,
    FAIL
  } state_t;

  function automatic logic [WORD_W-1:0] expected_resp(
    input logic [WORD_W-1:0] challenge,
    input logic [WORD_W-1:0] key
  );
    return challenge ^ key;
  endfunction

endpackage

// File: rtl/challenge_auth_if.sv
// challenge_auth_if
// Groups the LFSR step/word pair and the UART TX/RX byte paths used by the
// authentication sequencer.
//   lfsr_enable : sequencer -> LFSR, one-cycle step strobe
//   random      : LFSR -> sequencer, current 16-bit word
//   tx_data/tx_valid/tx_ready : byte stream to the UART transmitter
//   rx_data/rx_valid          : byte strobe from the UART receiver
// Modports:
//   master : the sequencer side
//   slave  : the LFSR/UART side
interface challenge_auth_if;
  import auth_pkg::*;

  logic                lfsr_enable;
  logic [WORD_W-1:0]   random;
  logic [BYTE_W-1:0]   tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic [BYTE_W-1:0]   rx_data;
  logic                rx_valid;

  modport master (
    output lfsr_enable,
    input  random,
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid
  );

  modport slave (
    input  lfsr_enable,
    output random,
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid
  );

endinterface

// File: rtl/auth_timeout.sv
// auth_timeout
// Response-window timer. A clear loads TIMEOUT_CYCLES-1; the count then
// decrements once per enabled cycle and holds at zero. expired is high while
// enabled with the count at zero, i.e. on the TIMEOUT_CYCLES-th enabled cycle
// after the clear.
// Ports:
//   clk, rst : clock, async active-high reset
//   clear    : reload the window (takes priority over enable)
//   enable   : count this cycle
//   expired  : window used up
module auth_timeout #(
  parameter int TIMEOUT_CYCLES = 12_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= LOAD;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = enable && (count == '0);

endmodule

// File: rtl/challenge_auth.sv
// challenge_auth
// Challenge-response authentication sequencer. On start it steps the LFSR,
// latches the new word as the challenge, sends it high byte first over the
// UART TX path, collects a two-byte response and compares it against
// challenge ^ KEY. The result drives the authorized level.
//
// Build option: define CHALLENGE_AUTH_LOCKOUT_EN to count consecutive
// failures and lock out further starts after MAX_FAILS of them (until rst).
//
// Ports:
//   clk, rst    : clock, async active-high reset
//   start       : one-cycle request, honoured only in IDLE and when unlocked
//   bus         : LFSR + UART signals (challenge_auth_if.master)
//   busy        : sequencer not in IDLE
//   auth_pass   : one-cycle pulse on matching response
//   auth_fail   : one-cycle pulse on mismatch or timeout
//   authorized  : set on pass, cleared on fail or a new start
//   locked      : lockout level (constant 0 without the lockout build)
//
// state | meaning
// IDLE  | waiting for start
// ROLL  | lfsr_enable strobe
// LATCH | capture post-step LFSR word as challenge
// TX_HI | offer challenge[15:8]
// TX_LO | offer challenge[7:0]
// RX_HI | wait for response high byte (timed)
// RX_LO | wait for response low byte (timed)
// CHECK | compare response with challenge ^ KEY
// PASS  | auth_pass pulse
// FAIL  | auth_fail pulse
module challenge_auth
  import auth_pkg::*;
#(
  parameter logic [WORD_W-1:0] KEY            = DEFAULT_KEY,
  parameter int                TIMEOUT_CYCLES = 12_000_000,
  parameter int                MAX_FAILS      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  challenge_auth_if.master bus,
  output logic             busy,
  output logic             auth_pass,
  output logic             auth_fail,
  output logic             authorized,
  output logic             locked
);

  if (TIMEOUT_CYCLES < 2 || MAX_FAILS < 1) begin : g_param_check
    $error("challenge_auth: TIMEOUT_CYCLES must be >= 2 and MAX_FAILS >= 1");
  end

  state_t            state;
  logic [WORD_W-1:0] challenge;
  logic [WORD_W-1:0] resp;

  logic tx_fire;
  logic tmo_clear;
  logic tmo_en;
  logic tmo_expired;
  logic resp_ok;
  logic go_fail;

  assign tx_fire   = bus.tx_valid && bus.tx_ready;
  assign tmo_clear = (state == TX_LO) && tx_fire;
  assign tmo_en    = (state == RX_HI) || (state == RX_LO);
  assign resp_ok   = (resp == expected_resp(challenge, KEY));

  // A byte arriving on the expiring cycle only rescues the low byte; in
  // RX_HI the timeout wins.
  assign go_fail = ((state == RX_HI) && tmo_expired) ||
                   ((state == RX_LO) && !bus.rx_valid && tmo_expired) ||
                   ((state == CHECK) && !resp_ok);

  auth_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmo_clear),
    .enable (tmo_en),
    .expired(tmo_expired)
  );

`ifdef CHALLENGE_AUTH_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAILS);

  logic [FW-1:0] fail_cnt;
  logic [FW-1:0] fail_cnt_inc;

  assign fail_cnt_inc = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + 1'b1;
`else
  assign locked = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      challenge       <= '0;
      resp            <= '0;
      busy            <= 1'b0;
      auth_pass       <= 1'b0;
      auth_fail       <= 1'b0;
      authorized      <= 1'b0;
      bus.lfsr_enable <= 1'b0;
      bus.tx_valid    <= 1'b0;
      bus.tx_data     <= '0;
`ifdef CHALLENGE_AUTH_LOCKOUT_EN
      fail_cnt        <= '0;
      locked          <= 1'b0;
`endif
    end else begin
      bus.lfsr_enable <= 1'b0;
      auth_pass       <= 1'b0;
      auth_fail       <= 1'b0;

      case (state)
        IDLE: begin
          if (start && !locked) begin
            state           <= ROLL;
            busy            <= 1'b1;
            authorized      <= 1'b0;
            bus.lfsr_enable <= 1'b1;
          end
        end
        ROLL: begin
          state <= LATCH;
        end
        LATCH: begin
          challenge    <= bus.random;
          bus.tx_data  <= bus.random[WORD_W-1:BYTE_W];
          bus.tx_valid <= 1'b1;
          state        <= TX_HI;
        end
        TX_HI: begin
          if (tx_fire) begin
            bus.tx_data <= challenge[BYTE_W-1:0];
            state       <= TX_LO;
          end
        end
        TX_LO: begin
          if (tx_fire) begin
            bus.tx_valid <= 1'b0;
            bus.tx_data  <= '0;
            state        <= RX_HI;
          end
        end
        RX_HI: begin
          if (tmo_expired) begin
            state <= FAIL;
          end else if (bus.rx_valid) begin
            resp[WORD_W-1:BYTE_W] <= bus.rx_data;
            state                 <= RX_LO;
          end
        end
        RX_LO: begin
          if (bus.rx_valid) begin
            resp[BYTE_W-1:0] <= bus.rx_data;
            state            <= CHECK;
          end else if (tmo_expired) begin
            state <= FAIL;
          end
        end
        CHECK: begin
          if (resp_ok) begin
            state      <= PASS;
            auth_pass  <= 1'b1;
            authorized <= 1'b1;
`ifdef CHALLENGE_AUTH_LOCKOUT_EN
            fail_cnt   <= '0;
`endif
          end else begin
            state <= FAIL;
          end
        end
        PASS, FAIL: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          bus.tx_valid <= 1'b0;
        end
      endcase

      // Common entry actions for FAIL; locked rises with this auth_fail.
      if (go_fail) begin
        auth_fail  <= 1'b1;
        authorized <= 1'b0;
`ifdef CHALLENGE_AUTH_LOCKOUT_EN
        fail_cnt   <= fail_cnt_inc;
        if (fail_cnt_inc == FAIL_MAX) begin
          locked <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_challenge_auth.sv
// tb_challenge_auth
// Directed bench for challenge_auth: pass, mismatch, backpressure, timeout,
// timeout/byte collision, reset mid-operation and (lockout build) lockout.
module tb_challenge_auth;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, auth_pass, auth_fail, authorized, locked;

  challenge_auth_if bus();

  challenge_auth #(
    .KEY           (16'h5A3C),
    .TIMEOUT_CYCLES(16),
    .MAX_FAILS     (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .auth_pass (auth_pass),
    .auth_fail (auth_fail),
    .authorized(authorized),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int lfsr_steps = 0;
  logic both_hi = 1'b0;

  always @(posedge clk) begin
    if (bus.lfsr_enable) lfsr_steps <= lfsr_steps + 1;
    if (auth_pass && auth_fail) both_hi <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_tx_valid(output int n);
    n = 0;
    while (!bus.tx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic take_byte(input string tag, input logic [7:0] exp);
    int n = 0;
    while (!(bus.tx_valid && bus.tx_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_txvalid"}, bus.tx_valid, 1'b1);
    chk({tag, "_txdata"}, bus.tx_data, exp);
    @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (!auth_pass && !auth_fail && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_auth(input string tag, input logic [15:0] rnd,
                          input logic [7:0] r_hi, input logic [7:0] r_lo,
                          input bit exp_pass, output logic lk);
    int n;
    int steps0;
    steps0 = lfsr_steps;
    bus.random   = rnd;
    bus.tx_ready = 1'b1;
    do_start();
    chk({tag, "_lfsr_en"}, bus.lfsr_enable, 1'b1);
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_auth_clr"}, authorized, 1'b0);
    wait_tx_valid(n);
    chk({tag, "_latency"}, n, 2);
    take_byte({tag, "_hi"}, rnd[15:8]);
    take_byte({tag, "_lo"}, rnd[7:0]);
    chk({tag, "_txvalid_drop"}, bus.tx_valid, 1'b0);
    send_rx(r_hi);
    send_rx(r_lo);
    wait_result(n);
    lk = locked;
    chk({tag, "_res_lat"}, n, 1);
    chk({tag, "_pass"}, auth_pass, exp_pass);
    chk({tag, "_fail"}, auth_fail, !exp_pass);
    chk({tag, "_authorized"}, authorized, exp_pass);
    chk({tag, "_steps"}, lfsr_steps - steps0, 1);
    @(negedge clk);
    chk({tag, "_idle"}, busy, 1'b0);
    chk({tag, "_pulse_end"}, auth_pass | auth_fail, 1'b0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int steps0;
    logic lk;

    bus.random   = '0;
    bus.tx_ready = 1'b0;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;

    // Reset state
    reset_dut();
    chk("rst_busy", busy, 1'b0);
    chk("rst_txvalid", bus.tx_valid, 1'b0);
    chk("rst_txdata", bus.tx_data, 8'h00);
    chk("rst_lfsr_en", bus.lfsr_enable, 1'b0);
    chk("rst_pulses", {auth_pass, auth_fail}, 2'b00);
    chk("rst_authorized", authorized, 1'b0);
    chk("rst_locked", locked, 1'b0);

    // Pass: 0x59C3 ^ 0x5A3C = 0x03FF
    run_auth("pass", 16'h59C3, 8'h03, 8'hFF, 1'b1, lk);

    // Mismatch: low byte off by one
    run_auth("mismatch", 16'h59C3, 8'h03, 8'hFE, 1'b0, lk);

    // Second pattern: 0xA5F0 ^ 0x5A3C = 0xFFCC
    run_auth("pass2", 16'hA5F0, 8'hFF, 8'hCC, 1'b1, lk);

    // Backpressure: tx_ready low 5 cycles in TX_HI; random changes after latch
    bus.random   = 16'h59C3;
    bus.tx_ready = 1'b0;
    do_start();
    wait_tx_valid(n);
    chk("bp_latency", n, 2);
    bus.random = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", bus.tx_valid, 1'b1);
      chk("bp_hold_data", bus.tx_data, 8'h59);
      @(negedge clk);
    end
    bus.tx_ready = 1'b1;
    take_byte("bp_hi", 8'h59);
    take_byte("bp_lo", 8'hC3);
    send_rx(8'h03);
    send_rx(8'hFF);
    wait_result(n);
    chk("bp_pass", auth_pass, 1'b1);
    chk("bp_authorized", authorized, 1'b1);
    @(negedge clk);

    // Timeout: one byte only, start pulsed while busy
    steps0 = lfsr_steps;
    bus.random = 16'h59C3;
    do_start();
    wait_tx_valid(n);
    take_byte("to_hi", 8'h59);
    take_byte("to_lo", 8'hC3);
    bus.rx_data  = 8'h03;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    n = 1;
    while (!auth_fail && !auth_pass && n < 40) begin
      start = (n == 8);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("to_cycles", n, 16);
    chk("to_fail", auth_fail, 1'b1);
    chk("to_pass", auth_pass, 1'b0);
    chk("to_authorized", authorized, 1'b0);
    chk("to_locked", locked, 1'b0);
    repeat (3) @(negedge clk);
    chk("to_busy_start_ignored", busy, 1'b0);
    chk("to_steps", lfsr_steps - steps0, 1);

    // Low byte on the expiring cycle wins
    bus.random = 16'h59C3;
    do_start();
    wait_tx_valid(n);
    take_byte("edge_hi", 8'h59);
    take_byte("edge_lo", 8'hC3);
    bus.rx_data  = 8'h03;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    n = 1;
    while (!auth_fail && !auth_pass && n < 40) begin
      if (n == 15) begin
        bus.rx_data  = 8'hFF;
        bus.rx_valid = 1'b1;
      end else begin
        bus.rx_valid = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.rx_valid = 1'b0;
    chk("edge_cycles", n, 17);
    chk("edge_pass", auth_pass, 1'b1);
    @(negedge clk);

    // Reset in TX_LO
    bus.random   = 16'h1357;
    bus.tx_ready = 1'b0;
    do_start();
    wait_tx_valid(n);
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.tx_ready = 1'b0;
    chk("rmid_txlo_data", bus.tx_data, 8'h57);
    #2 rst = 1'b1;
    #1;
    chk("rmid_txvalid", bus.tx_valid, 1'b0);
    chk("rmid_busy", busy, 1'b0);
    chk("rmid_authorized", authorized, 1'b0);
    chk("rmid_pulses", {auth_pass, auth_fail}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // 0x1357 ^ 0x5A3C = 0x496B
    run_auth("post_rst", 16'h1357, 8'h49, 8'h6B, 1'b1, lk);

`ifdef CHALLENGE_AUTH_LOCKOUT_EN
    reset_dut();
    run_auth("lk1", 16'h59C3, 8'h03, 8'hFE, 1'b0, lk);
    chk("lk1_locked", lk, 1'b0);
    run_auth("lk2", 16'h59C3, 8'h03, 8'hFE, 1'b0, lk);
    chk("lk2_locked", lk, 1'b0);
    run_auth("lk3", 16'h59C3, 8'h03, 8'hFE, 1'b0, lk);
    chk("lk3_locked", lk, 1'b1);
    steps0 = lfsr_steps;
    do_start();
    repeat (2) @(negedge clk);
    chk("lk4_busy", busy, 1'b0);
    chk("lk4_steps", lfsr_steps - steps0, 0);
    chk("lk4_locked", locked, 1'b1);
`endif

    chk("never_both_pulses", both_hi, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
